// File: rtl/mem_copy_engine.sv
// Block-transfer bus master for the 256-word data memory: copies or fills a
// run of words, one memory access per cycle, then pulses done.
module mem_copy_engine #(
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data,
    output logic             mem_read_en,
    output logic             mem_write_en
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FILL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [31:0]      data_buf;
    logic [31:0]      fill_reg;
    logic             desc;
    logic [31:0]      len_ext;
    logic             go_desc;

    assign len_ext = {{(32 - LEN_W){1'b0}}, length};
    // Descending order keeps an overlapping forward move from clobbering unread source words.
    assign go_desc = ~mode && (dst_addr > src_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            data_buf <= '0;
            fill_reg <= '0;
            desc     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= length;
                        fill_reg <= fill_value;
                        desc     <= go_desc;
                        if (go_desc) begin
                            src_ptr <= src_addr + len_ext - 32'd1;
                            dst_ptr <= dst_addr + len_ext - 32'd1;
                        end else begin
                            src_ptr <= src_addr;
                            dst_ptr <= dst_addr;
                        end
                    end
                end
                READ: begin
                    data_buf <= mem_read_data;
                end
                WRITE: begin
                    src_ptr <= desc ? src_ptr - 32'd1 : src_ptr + 32'd1;
                    dst_ptr <= desc ? dst_ptr - 32'd1 : dst_ptr + 32'd1;
                    cnt     <= cnt - LEN_W'(1);
                end
                FILL: begin
                    dst_ptr <= dst_ptr + 32'd1;
                    cnt     <= cnt - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        busy           = 1'b0;
        done           = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_next = DONE;
                    end else if (mode) begin
                        state_next = FILL;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                busy        = 1'b1;
                mem_address = src_ptr;
                mem_read_en = 1'b1;
                state_next  = WRITE;
            end
            WRITE: begin
                busy           = 1'b1;
                mem_address    = dst_ptr;
                mem_write_data = data_buf;
                mem_write_en   = 1'b1;
                state_next     = (cnt == LEN_W'(1)) ? DONE : READ;
            end
            FILL: begin
                busy           = 1'b1;
                mem_address    = dst_ptr;
                mem_write_data = fill_reg;
                mem_write_en   = 1'b1;
                state_next     = (cnt == LEN_W'(1)) ? DONE : FILL;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Reset must never coincide with a memory access.
        if (rst) begin
            mem_read_en  = 1'b0;
            mem_write_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: expected memory accesses and done
// pulses are queued per command and popped by an independent monitor.
module tb_mem_copy_engine;

    localparam logic [1:0] K_RD = 2'd0;
    localparam logic [1:0] K_WR = 2'd1;
    localparam logic [1:0] K_DN = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [8:0]  length;
    logic [31:0] fill_value;
    logic        busy;
    logic        done;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read_en;
    logic        mem_write_en;

    logic [31:0] mem [0:255];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_wa = 8'd0;
    logic [31:0] tb_wd = 32'd0;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.LEN_W(9)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .fill_value     (fill_value),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en)
    );

    assign mem_read_data = mem[mem_address[7:0]];

    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (mem_write_en) mem[mem_address[7:0]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [8:0] l, input logic [31:0] f);
        @(negedge clk);
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        length     = l;
        fill_value = f;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the edge that samples start.
    task automatic wait_done(input int c0, input int exp, input string name);
        int  c = c0;
        bit  seen = 1'b0;
        while (!seen && c < 600) begin
            @(negedge clk);
            c++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: done never seen within 600 cycles", name);
        end else begin
            chk(name, c, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_addr"},  mem_address, 32'd0);
        chk({tag, "_wdata"}, mem_write_data, 32'd0);
        chk({tag, "_re"},    {31'd0, mem_read_en}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_write_en}, 32'd0);
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pop on every access or done.
    always @(negedge clk) begin
        ev_t         e;
        logic [1:0]  k;
        if (!rst) begin
            chk("busy_vs_access", {31'd0, busy}, {31'd0, mem_read_en | mem_write_en});
            chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
            chk("rd_wr_excl", {31'd0, mem_read_en & mem_write_en}, 32'd0);
        end
        if (mem_read_en || mem_write_en || done) begin
            k = mem_write_en ? K_WR : (mem_read_en ? K_RD : K_DN);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: kind %0d addr %h with empty queue, expected none", k, mem_address);
            end else begin
                e = q.pop_front();
                chk("event_kind", {30'd0, k}, {30'd0, e.kind});
                if (e.kind != K_DN) chk("event_addr", mem_address, e.addr);
                if (e.kind == K_WR) chk("event_wdata", mem_write_data, e.data);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;

        for (int i = 0; i < 256; i++) poke(i[7:0], 32'd0);
        for (int i = 0; i < 4; i++) poke(8'h20 + i[7:0], 32'd1 + i);
        poke(8'h02, 32'hA);
        poke(8'h03, 32'hB);
        for (int i = 0; i < 4; i++) poke(8'h70 + i[7:0], 32'h11 + i);
        @(posedge clk);
        #1 chk_outputs_zero("reset");
        rst = 1'b0;

        // Fill of 4 words
        for (int i = 0; i < 4; i++) push(K_WR, 32'h10 + i, 32'hDEADBEEF);
        push(K_DN, 0, 0);
        issue(1'b1, 32'h0, 32'h10, 9'd4, 32'hDEADBEEF);
        wait_done(0, 5, "fill_done_cycle");
        for (int i = 0; i < 4; i++) chk("fill_mem", mem[8'h10 + i[7:0]], 32'hDEADBEEF);

        // Forward-overlap copy runs descending
        push(K_RD, 32'h23, 0); push(K_WR, 32'h25, 32'd4);
        push(K_RD, 32'h22, 0); push(K_WR, 32'h24, 32'd3);
        push(K_RD, 32'h21, 0); push(K_WR, 32'h23, 32'd2);
        push(K_RD, 32'h20, 0); push(K_WR, 32'h22, 32'd1);
        push(K_DN, 0, 0);
        issue(1'b0, 32'h20, 32'h22, 9'd4, 32'h0);
        wait_done(0, 9, "overlap_done_cycle");
        chk("overlap_mem20", mem[8'h20], 32'd1);
        chk("overlap_mem21", mem[8'h21], 32'd2);
        chk("overlap_mem22", mem[8'h22], 32'd1);
        chk("overlap_mem23", mem[8'h23], 32'd2);
        chk("overlap_mem24", mem[8'h24], 32'd3);
        chk("overlap_mem25", mem[8'h25], 32'd4);

        // Copy across the top of the array; dst > src so it runs descending
        push(K_RD, 32'h03, 0); push(K_WR, 32'h100, 32'hB);
        push(K_RD, 32'h02, 0); push(K_WR, 32'hFF, 32'hA);
        push(K_DN, 0, 0);
        issue(1'b0, 32'h02, 32'hFF, 9'd2, 32'h0);
        wait_done(0, 5, "wrap_done_cycle");
        chk("wrap_memFF", mem[8'hFF], 32'hA);
        chk("wrap_mem00", mem[8'h00], 32'hB);

        // Zero length: only a done pulse
        push(K_DN, 0, 0);
        issue(1'b0, 32'h30, 32'h40, 9'd0, 32'h0);
        wait_done(0, 1, "zero_done_cycle");

        // Second start during a 3-word fill is dropped
        for (int i = 0; i < 3; i++) push(K_WR, 32'h40 + i, 32'h55);
        push(K_DN, 0, 0);
        issue(1'b1, 32'h0, 32'h40, 9'd3, 32'h55);
        issue(1'b1, 32'h0, 32'h50, 9'd5, 32'h66);
        wait_done(1, 4, "busy_start_done_cycle");
        chk("busy_start_mem42", mem[8'h42], 32'h55);
        chk("busy_start_mem43", mem[8'h43], 32'h0);
        chk("busy_start_mem50", mem[8'h50], 32'h0);

        // Reset during the second WRITE of a 4-word ascending copy
        push(K_RD, 32'h70, 0); push(K_WR, 32'h60, 32'h11);
        push(K_RD, 32'h71, 0);
        issue(1'b0, 32'h70, 32'h60, 9'd4, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_we", {31'd0, mem_write_en}, 32'd0);
        chk("rst_cycle_re", {31'd0, mem_read_en}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_outputs_zero("after_abort");
        chk("abort_mem60", mem[8'h60], 32'h11);
        chk("abort_mem61", mem[8'h61], 32'h0);
        repeat (3) @(negedge clk);
        chk("abort_mem62", mem[8'h62], 32'h0);

        // Normal command after the abort
        push(K_WR, 32'h80, 32'h7); push(K_WR, 32'h81, 32'h7);
        push(K_DN, 0, 0);
        issue(1'b1, 32'h0, 32'h80, 9'd2, 32'h7);
        wait_done(0, 3, "post_reset_done_cycle");
        chk("post_reset_mem81", mem[8'h81], 32'h7);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
